// File: rtl/muxn_pkg.sv
// Shared types and helpers for the muxn_scan time-division readout multiplexer.
package muxn_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Bit width needed to index n items, never less than one bit so that
  // degenerate sizes still yield a legal vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/muxn_scan_rr_next_sel.sv
// rr_next_sel: purely combinational circular "next set bit after idx" search.
// Each set bit is ranked by its circular distance past idx_i (idx_i itself
// ranks last), which is a priority pick over the mask rotated to start at
// idx_i+1. wrapped_o flags that the winner is at or below idx_i.
module rr_next_sel
  import muxn_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] next_o,
  output logic             wrapped_o
);

  int best_s;
  int best_dist_s;
  int dist_s;

  // Pick the set bit with the smallest circular distance past idx_i.
  always_comb begin
    best_s      = int'(idx_i);
    best_dist_s = N + 1;
    dist_s      = 0;
    for (int k = 0; k < N; k++) begin
      if (k > int'(idx_i)) begin
        dist_s = k - int'(idx_i);
      end else begin
        dist_s = k - int'(idx_i) + N;
      end
      if (mask_i[k] && (dist_s < best_dist_s)) begin
        best_s      = k;
        best_dist_s = dist_s;
      end else begin
        best_s      = best_s;
      end
    end
    next_o    = IDX_W'(best_s);
    wrapped_o = (best_s <= int'(idx_i));
  end

endmodule

// File: rtl/muxn_scan.sv
// muxn_scan: parametrised N:1 word multiplexer with registered output,
// direct-select mode and auto-scan over a channel mask with programmable dwell.
// Optional build macro MUXN_SCAN_PARITY_EN adds y_par, the even parity of y.
module muxn_scan
  import muxn_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 16,
  parameter int DWELL    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       chan_mask,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      wrap,
`ifdef MUXN_SCAN_PARITY_EN
  output logic                      y_par,
`endif
  output logic                      sel_err
);

  localparam int                 DW_W     = clog2_min1(DWELL);
  localparam logic [DW_W-1:0]    RELOAD   = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]     CH_LIMIT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam int                 NWORDS   = 1 << SEL_W;

  // Word table padded to a power of two so any select value indexes safely.
  logic [WIDTH-1:0] word_s [NWORDS];

  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    if (k < CHANNELS) begin : g_real
      assign word_s[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign word_s[k] = {WIDTH{1'b0}};
    end
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  mode_e            mode_s;
  logic             mask_any_s;
  logic             sel_ok_s;
  logic [SEL_W-1:0] search_idx_s;
  logic [SEL_W-1:0] next_ch_s;
  logic             next_wrap_s;

  assign mode_s     = mode_e'(mode);
  assign mask_any_s = |chan_mask;
  assign sel_ok_s   = ({1'b0, sel} < CH_LIMIT);

  // Searching "after the last channel" from IDLE lands on the lowest enabled one.
  assign search_idx_s = (state_q == IDLE) ? LAST_CH : ptr_q;

  rr_next_sel #(
    .N     (CHANNELS),
    .IDX_W (SEL_W)
  ) u_next_sel (
    .mask_i    (chan_mask),
    .idx_i     (search_idx_s),
    .next_o    (next_ch_s),
    .wrapped_o (next_wrap_s)
  );

  // State register: synchronous reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: direct mode or an empty mask drop to IDLE; en=0 freezes.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = state_q;
    end else if (mode_s == MODE_DIRECT) begin
      state_d = IDLE;
    end else if (!mask_any_s) begin
      state_d = IDLE;
    end else begin
      state_d = SCAN;
    end
  end

  // Output/datapath next values: sample, dwell countdown and pointer advance.
  always_comb begin
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    wrap_d    = 1'b0;
    sel_err_d = sel_err_q;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;
    if (!en) begin
      y_valid_d = 1'b0;
    end else if (mode_s == MODE_DIRECT) begin
      if (sel_ok_s) begin
        y_d       = word_s[sel];
        y_ch_d    = sel;
        y_valid_d = 1'b1;
        sel_err_d = 1'b0;
      end else begin
        y_d       = {WIDTH{1'b0}};
        sel_err_d = 1'b1;
      end
    end else if (!mask_any_s) begin
      y_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ptr_d     = next_ch_s;
          y_d       = word_s[next_ch_s];
          y_ch_d    = next_ch_s;
          y_valid_d = 1'b1;
          dwell_d   = RELOAD;
          sel_err_d = 1'b0;
        end
        SCAN: begin
          if (|dwell_q) begin
            dwell_d = dwell_q - DW_W'(1'b1);
          end else begin
            ptr_d     = next_ch_s;
            y_d       = word_s[next_ch_s];
            y_ch_d    = next_ch_s;
            y_valid_d = 1'b1;
            wrap_d    = next_wrap_s;
            dwell_d   = RELOAD;
          end
        end
        default: begin
          y_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= {WIDTH{1'b0}};
      y_ch_q    <= {SEL_W{1'b0}};
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
      ptr_q     <= {SEL_W{1'b0}};
      dwell_q   <= {DW_W{1'b0}};
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign wrap    = wrap_q;
  assign sel_err = sel_err_q;

`ifdef MUXN_SCAN_PARITY_EN
  logic y_par_q;

  // Even parity of a word: XOR of all its bits.
  function automatic logic par_even(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Parity flop tracks y_d, so it updates and holds exactly with y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par_q <= 1'b0;
    end else begin
      y_par_q <= par_even(y_d);
    end
  end

  assign y_par = y_par_q;
`endif

endmodule

// File: tb/tb_muxn_scan.sv
// Scoreboard bench for muxn_scan: three DUT configurations share one stimulus
// stream; a queue-based reference model predicts each sample.
module tb_muxn_scan;

  localparam int ND = 3;
  localparam int CH_A [ND] = '{16, 16, 12};
  localparam int DW_A [ND] = '{1, 3, 2};

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] ch;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [3:0]  sel;
  logic [15:0] chan_mask;
  logic [63:0] din;

  logic [3:0] y_w   [ND];
  logic [3:0] ych_w [ND];
  logic       yv_w  [ND];
  logic       wrap_w[ND];
  logic       err_w [ND];
`ifdef MUXN_SCAN_PARITY_EN
  logic       par_w [ND];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    muxn_scan #(
      .WIDTH    (4),
      .CHANNELS (CH_A[g]),
      .DWELL    (DW_A[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din[CH_A[g]*4-1:0]),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .chan_mask (chan_mask[CH_A[g]-1:0]),
      .y         (y_w[g]),
      .y_ch      (ych_w[g]),
      .y_valid   (yv_w[g]),
      .wrap      (wrap_w[g]),
`ifdef MUXN_SCAN_PARITY_EN
      .y_par     (par_w[g]),
`endif
      .sel_err   (err_w[g])
    );
  end

  // Reference model state, one slot per DUT.
  int         m_state [ND];
  int         m_ptr   [ND];
  int         m_dwell [ND];
  logic [3:0] m_y     [ND];
  logic       m_valid [ND];
  logic       m_err   [ND];

  exp_t q0[$], q1[$], q2[$];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void clear_q(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] word_of(input logic [63:0] v, input int ch);
    return v[ch*4 +: 4];
  endfunction

  function automatic void sample(input int d, input int ch, input logic w);
    exp_t e;
    m_y[d]     = word_of(din, ch);
    m_valid[d] = 1'b1;
    e.y        = m_y[d];
    e.ch       = 4'(ch);
    e.wrap     = w;
    push_exp(d, e);
  endfunction

  // Reference model: list the enabled channels, then pick from that list.
  task automatic model_step(input int d);
    int en_ch[$];
    int nxt;
    m_valid[d] = 1'b0;
    if (rst) begin
      m_state[d] = 0; m_ptr[d] = 0; m_dwell[d] = 0;
      m_y[d] = 4'h0; m_err[d] = 1'b0;
      clear_q(d);
      return;
    end
    if (!en) return;
    if (mode == 1'b0) begin
      m_state[d] = 0;
      if (int'(sel) < CH_A[d]) begin
        sample(d, int'(sel), 1'b0);
        m_err[d] = 1'b0;
      end else begin
        m_y[d]   = 4'h0;
        m_err[d] = 1'b1;
      end
      return;
    end
    for (int k = 0; k < CH_A[d]; k++) if (chan_mask[k]) en_ch.push_back(k);
    if (en_ch.size() == 0) begin
      m_state[d] = 0;
    end else if (m_state[d] == 0) begin
      m_state[d] = 1;
      m_err[d]   = 1'b0;
      m_ptr[d]   = en_ch[0];
      m_dwell[d] = DW_A[d] - 1;
      sample(d, m_ptr[d], 1'b0);
    end else if (m_dwell[d] > 0) begin
      m_dwell[d]--;
    end else begin
      nxt = -1;
      foreach (en_ch[i]) if (nxt < 0 && en_ch[i] > m_ptr[d]) nxt = en_ch[i];
      m_dwell[d] = DW_A[d] - 1;
      if (nxt < 0) begin
        m_ptr[d] = en_ch[0];
        sample(d, m_ptr[d], 1'b1);
      end else begin
        m_ptr[d] = nxt;
        sample(d, m_ptr[d], 1'b0);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic m, input logic [3:0] s,
                     input logic [15:0] k, input logic [63:0] dv);
    @(negedge clk);
    rst = r; en = e; mode = m; sel = s; chan_mask = k; din = dv;
    for (int d = 0; d < ND; d++) model_step(d);
  endtask

  // Monitor: per-cycle status checks, sample content popped from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        for (int d = 0; d < ND; d++) begin
          chk("y_valid", d, int'(yv_w[d]), int'(m_valid[d]));
          chk("sel_err", d, int'(err_w[d]), int'(m_err[d]));
`ifdef MUXN_SCAN_PARITY_EN
          chk("y_par", d, int'(par_w[d]), int'(^m_y[d]));
`endif
          if (yv_w[d]) begin
            chk("sb_has_entry", d, int'(q_size(d) > 0), 1);
            if (q_size(d) > 0) begin
              e = pop_exp(d);
              chk("y", d, int'(y_w[d]), int'(e.y));
              chk("y_ch", d, int'(ych_w[d]), int'(e.ch));
              chk("wrap", d, int'(wrap_w[d]), int'(e.wrap));
            end
          end else begin
            chk("y_hold", d, int'(y_w[d]), int'(m_y[d]));
            chk("wrap_quiet", d, int'(wrap_w[d]), 0);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized soak.
  initial begin
    logic [63:0] dk;
    logic [15:0] rmask;
    logic        rmode;
    int          pick;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 4'h0; chan_mask = 16'h0000; din = 64'h0;
    for (int k = 0; k < 16; k++) dk[k*4 +: 4] = 4'(k + 1);

    cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'hFFFF, dk);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'hFFFF, dk);

    // Direct select, including out-of-range selects for the 12-channel build.
    cyc(1'b0, 1'b1, 1'b0, 4'd5,  16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd13, 16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd11, 16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd12, 16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd10, 16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd8,  16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd15, 16'hFFFF, dk);
    cyc(1'b0, 1'b0, 1'b0, 4'd2,  16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd0,  16'hFFFF, dk);

    // Full-mask scan, then a direct interruption mid-dwell and a restart.
    repeat (40) cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'hFFFF, dk);
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 16'hFFFF, dk);
    repeat (10) cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'hFFFF, dk);

    // Sparse mask, en dropped mid-dwell, mask emptied, single channel.
    cyc(1'b0, 1'b1, 1'b0, 4'd1, 16'h8421, dk);
    repeat (30) cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'h8421, dk);
    repeat (4)  cyc(1'b0, 1'b0, 1'b1, 4'd0, 16'h8421, dk);
    repeat (6)  cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'h8421, dk);
    repeat (3)  cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'h0000, dk);
    repeat (8)  cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'h8421, dk);
    repeat (10) cyc(1'b0, 1'b1, 1'b1, 4'd0, 16'h0040, dk);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 16'hFFFF, dk);

    // Randomized soak.
    rmask = 16'hFFFF;
    rmode = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) rmode = ~rmode;
      if ($urandom_range(0, 14) == 0) begin
        pick = $urandom_range(0, 4);
        case (pick)
          0: rmask = 16'h0000;
          1: rmask = 16'h0001 << $urandom_range(0, 15);
          2: rmask = 16'hFFFF;
          default: rmask = 16'($urandom);
        endcase
      end
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0), rmode,
          4'($urandom_range(0, 15)), rmask, {$urandom, $urandom});
    end

    cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, dk);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, dk);
    @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) chk("sb_drained", d, q_size(d), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
- Parametrised N:1 word multiplexer, the successor to the fixed 16:1 × 4-bit mux.
- Adds a registered output, a direct-select mode and an auto-scan mode.
- In scan mode an internal pointer steps through the channels enabled in a mask, holding each channel for a programmable dwell.
- Sits between parallel sample sources and a single serial consumer (display/ADC-style time-division readout).

Parameters:
- WIDTH, 4: bits per channel word.
- CHANNELS, 16: number of input channels, range 2..256.
- DWELL, 1: cycles each channel is held in scan mode, must be >= 1.
- SEL_W, $clog2(CHANNELS): localparam, select/pointer width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CHANNELS*WIDTH  packed channel words; channel k occupies din[k*WIDTH +: WIDTH].
- en  in  1  global advance enable.
- mode  in  1  0 = direct select, 1 = auto-scan.
- sel  in  SEL_W  channel select in direct mode.
- chan_mask  in  CHANNELS  scan enable per channel; bit k = 1 means channel k is visited.
- y  out  WIDTH  registered selected word.
- y_ch  out  SEL_W  channel index that produced y.
- y_valid  out  1  pulse, 1 cycle: y/y_ch are a new sample.
- wrap  out  1  pulse, 1 cycle: scan wrapped from highest enabled channel to lowest.
- sel_err  out  1  registered: direct sel >= CHANNELS.

Behaviour:
- Single clock domain.
- Reset (synchronous, active-high): y=0, y_ch=0, y_valid=0, wrap=0, sel_err=0, ptr=0, dwell_cnt=0, state=IDLE. Reset mid-scan aborts the scan with no partial output.
- Latency: 1 cycle from input sampling to y.
- en=0: all registers hold, y_valid=0, wrap=0. The dwell counter and pointer freeze.
- Direct mode (mode=0, en=1), every cycle:
  - sel < CHANNELS: y <= din[sel], y_ch <= sel, y_valid <= 1, sel_err <= 0.
  - sel >= CHANNELS: y <= 0, y_valid <= 0, sel_err <= 1.
  - state forced to IDLE.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN when mode=1, en=1 and chan_mask != 0. ptr loads the lowest set mask bit, that channel is sampled (y_valid=1), and dwell_cnt loads DWELL-1.
  - SCAN with dwell_cnt != 0: decrement, y holds, y_valid=0.
  - SCAN with dwell_cnt == 0: ptr <= next set mask bit above ptr, circularly; sample that channel, y_valid=1, reload dwell_cnt.
    - If the search wrapped (next <= ptr), wrap=1 that cycle.
    - With a single enabled channel, every sample asserts wrap.
  - SCAN -> IDLE when mode=0 (direct behaviour applies that same cycle) or chan_mask==0 (y holds, y_valid=0).
- chan_mask change mid-scan: takes effect at the next advance. If the current ptr bit is cleared, the current dwell completes first.
- Re-entering SCAN always restarts at the lowest enabled channel.
- sel_err is updated only in direct mode with en=1; it clears on entering SCAN.
- Next-channel search is combinational priority logic over a rotated mask; there is no multi-cycle search.
- With DWELL=1, a new sample is produced every enabled cycle.

Optional Feature:
- Macro MUXN_SCAN_PARITY_EN.
- Defined: adds output y_par (1 bit, registered with y) = even parity (XOR-reduce) of y. Reset value 0. It holds whenever y holds.
- Undefined: port y_par does not exist; all other behaviour is identical.

Decomposition:
- Package muxn_pkg holds:
  - typedef mode_e {MODE_DIRECT=0, MODE_SCAN=1};
  - typedef state_e {IDLE, SCAN};
  - function clog2_min1 (returns >= 1).
- One sub-module, rr_next_sel: purely combinational "next set bit after index, circular" search over CHANNELS bits, returning index and wrapped flag. It is reusable by other arbiters in the codebase.

Test Plan:
- Reset: assert rst with mode=1, mask=16'hFFFF. Next cycle y=0, y_ch=0, y_valid=0, wrap=0, state IDLE.
- Direct: din[k]=k+1, mode=0, en=1, sel=5. Next cycle y=4'h6, y_ch=5, y_valid=1. With CHANNELS=12, sel=13 gives sel_err=1, y=0, y_valid=0.
- Scan, full mask, DWELL=1, CHANNELS=16: y_ch sequence 0,1,…,15,0, with y_valid high every cycle. wrap=1 only on the cycle y_ch returns to 0.
- Scan, sparse mask 16'h8421, DWELL=3: y_ch sequence 0,5,10,15,0, each held 3 cycles. y_valid pulses once per channel, wrap on the return to 0.
- Scan interrupted:
  - Drop en for 4 cycles mid-dwell: outputs and dwell count freeze, then resume at the exact remaining count.
  - Switch mode to 0 mid-dwell: direct sample appears the next cycle.
  - mask=0: y holds, y_valid stays 0, state returns to IDLE.
- MUXN_SCAN_PARITY_EN build: y=4'b1011 gives y_par=1, y=4'b1001 gives y_par=0. In the build without the macro, the port is absent and the bench compiles without it.
